// File: rtl/pixel_plot_if.sv
// Handshake bundle between the line drawer, the pixel plot writer and the framebuffer port.
// The master side drives pixels and write acks; the slave side is the writer itself.
interface pixel_plot_if;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_x;
    logic [10:0] in_y;
    logic        in_color;
    logic        line_done;
    logic [18:0] fb_addr;
    logic        fb_data;
    logic        fb_we;
    logic        fb_ack;
    logic        flushed;
    logic [15:0] clip_count;

    modport master (
        output in_valid, in_x, in_y, in_color, line_done, fb_ack,
        input  in_ready, fb_addr, fb_data, fb_we, flushed, clip_count
    );

    modport slave (
        input  in_valid, in_x, in_y, in_color, line_done, fb_ack,
        output in_ready, fb_addr, fb_data, fb_we, flushed, clip_count
    );
endinterface

// File: rtl/pixel_plot_writer.sv
// Buffers on-screen pixels from the line drawer in a small FIFO and writes them one at a
// time to a 1-bit framebuffer, dropping and counting any pixel that falls off the screen.
module pixel_plot_writer #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input logic         clk,
    input logic         reset,
    pixel_plot_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic [10:0] W_LIM = 11'(SCREEN_W);
    localparam logic [10:0] H_LIM = 11'(SCREEN_H);
    localparam logic [18:0] W_MUL = 19'(SCREEN_W);
    localparam logic [AW:0] FULL  = (AW + 1)'(DEPTH);

    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic [18:0]   addr_q;
    logic          data_q;
    logic          flushed_q;
    logic [15:0]   clip_q;
    logic [19:0]   head;
    logic          accept;
    logic          on_screen;
    logic          push;
    logic          pop;

    // Readiness comes only from the registered occupancy, so a full FIFO refuses a pixel
    // even when the write side is popping in the same cycle.
    assign bus.in_ready = (count < FULL);
    assign accept       = bus.in_valid & bus.in_ready;
    assign on_screen    = ~bus.in_x[10] & ~bus.in_y[10] & (bus.in_x < W_LIM) & (bus.in_y < H_LIM);
    assign push         = accept & on_screen;
    assign pop          = (state == LOAD);
    assign head         = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.in_x[9:0], bus.in_y[8:0], bus.in_color};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry layout is {x[9:0], y[8:0], color}; the address is computed once in LOAD and
    // then held for as long as the framebuffer keeps the write waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) state <= LOAD;
                end
                LOAD: begin
                    addr_q <= 19'(head[9:1]) * W_MUL + 19'(head[19:10]);
                    data_q <= head[0];
                    state  <= WRITE;
                end
                WRITE: begin
                    if (bus.fb_ack) state <= (count != '0) ? LOAD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clip_q    <= '0;
            flushed_q <= 1'b0;
        end else begin
            if (accept && !on_screen && clip_q != 16'hFFFF) begin
                clip_q <= clip_q + 1'b1;
            end
            flushed_q <= bus.line_done & (count == '0) & (state == IDLE) & ~bus.in_valid;
        end
    end

    assign bus.fb_we      = (state == WRITE);
    assign bus.fb_addr    = addr_q;
    assign bus.fb_data    = data_q;
    assign bus.flushed    = flushed_q;
    assign bus.clip_count = clip_q;
endmodule

// File: tb/tb_pixel_plot_writer.sv
// Directed bench for pixel_plot_writer: latency, clipping, backpressure, flush, reset
// during a pending write and clip counter saturation.
module tb_pixel_plot_writer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   we_cycles = 0;
    logic [19:0] wr_q[$];

    pixel_plot_if bus();

    pixel_plot_writer #(
        .DEPTH(8),
        .SCREEN_W(640),
        .SCREEN_H(480)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Records every acknowledged framebuffer write as {addr, data}
    always @(posedge clk) begin
        if (bus.fb_we) begin
            we_cycles++;
            if (bus.fb_ack) wr_q.push_back({bus.fb_addr, bus.fb_data});
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic apply_pixel(input int x, input int y, input logic color);
        int waited;
        waited = 0;
        bus.in_x     = 11'(x);
        bus.in_y     = 11'(y);
        bus.in_color = color;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            checks++;
            errors++;
            $error("[TB] FAIL accept_timeout observed=stalled expected=ready");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n, input string tag);
        int waited;
        waited = 0;
        while (wr_q.size() < n && waited < 500) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (wr_q.size() < n) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, wr_q.size(), n);
        end
    endtask

    initial begin
        int   base;
        int   base_we;
        int   acc;
        logic rdy;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_color  = 1'b0;
        bus.line_done = 1'b0;
        bus.fb_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] reset state");
        check_output("rst_in_ready", bus.in_ready, 1);
        check_output("rst_fb_we", bus.fb_we, 0);
        check_output("rst_fb_addr", bus.fb_addr, 0);
        check_output("rst_fb_data", bus.fb_data, 0);
        check_output("rst_flushed", bus.flushed, 0);
        check_output("rst_clip", bus.clip_count, 0);

        $display("[TB] single pixel latency");
        bus.fb_ack = 1'b1;
        base    = wr_q.size();
        base_we = we_cycles;
        apply_pixel(5, 3, 1'b1);
        check_output("lat_e0_we", bus.fb_we, 0);
        @(posedge clk); #1;
        check_output("lat_e1_we", bus.fb_we, 0);
        @(posedge clk); #1;
        check_output("lat_e2_we", bus.fb_we, 1);
        check_output("lat_addr", bus.fb_addr, 1925);
        check_output("lat_data", bus.fb_data, 1);
        @(posedge clk); #1;
        check_output("lat_e3_we", bus.fb_we, 0);
        repeat (4) @(posedge clk);
        #1;
        check_output("lat_writes", wr_q.size() - base, 1);
        check_output("lat_we_pulse", we_cycles - base_we, 1);

        $display("[TB] clipping");
        base = wr_q.size();
        apply_pixel(-1, 0, 1'b1);
        apply_pixel(640, 0, 1'b1);
        apply_pixel(0, 480, 1'b1);
        apply_pixel(639, 479, 1'b1);
        wait_writes(base + 1, "clip_wait");
        repeat (4) @(posedge clk);
        #1;
        check_output("clip_writes", wr_q.size() - base, 1);
        check_output("clip_addr", 32'(wr_q[base][19:1]), 307199);
        check_output("clip_data", 32'(wr_q[base][0]), 1);
        check_output("clip_count", bus.clip_count, 3);

        $display("[TB] backpressure");
        bus.fb_ack = 1'b0;
        base = wr_q.size();
        acc  = 0;
        for (int c = 0; c < 30; c++) begin
            bus.in_x     = 11'(acc);
            bus.in_y     = 11'd1;
            bus.in_color = acc[0];
            bus.in_valid = 1'b1;
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (!rdy) break;
            acc++;
        end
        check_output("bp_accepted", acc, 9);
        check_output("bp_ready_low", bus.in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check_output("bp_ready_held", bus.in_ready, 0);
        check_output("bp_no_write", wr_q.size() - base, 0);
        bus.in_valid = 1'b0;
        bus.fb_ack   = 1'b1;
        wait_writes(base + 9, "bp_wait");
        repeat (6) @(posedge clk);
        #1;
        check_output("bp_writes", wr_q.size() - base, 9);
        for (int i = 0; i < 9; i++) begin
            check_output($sformatf("bp_order_%0d", i), 32'(wr_q[base + i]), 32'({19'(640 + i), i[0]}));
        end

        $display("[TB] flush");
        bus.fb_ack = 1'b0;
        base = wr_q.size();
        for (int i = 0; i < 4; i++) begin
            apply_pixel(10 + i, 2, 1'b1);
        end
        bus.line_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("flush_pending", bus.flushed, 0);
        bus.fb_ack = 1'b1;
        wait_writes(base + 4, "flush_wait");
        check_output("flush_at_ack", bus.flushed, 0);
        @(posedge clk); #1;
        check_output("flush_set", bus.flushed, 1);
        check_output("flush_last_addr", 32'(wr_q[base + 3][19:1]), 2 * 640 + 13);
        bus.line_done = 1'b0;
        @(posedge clk); #1;
        check_output("flush_clear", bus.flushed, 0);

        $display("[TB] reset during write");
        bus.fb_ack = 1'b0;
        base = wr_q.size();
        for (int i = 0; i < 4; i++) begin
            apply_pixel(20 + i, 4, 1'b1);
        end
        check_output("rw_pre_we", bus.fb_we, 1);
        check_output("rw_pre_clip", bus.clip_count, 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_output("rw_we", bus.fb_we, 0);
        check_output("rw_ready", bus.in_ready, 1);
        check_output("rw_clip", bus.clip_count, 0);
        check_output("rw_addr", bus.fb_addr, 0);
        bus.fb_ack = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_output("rw_no_writes", wr_q.size() - base, 0);
        check_output("rw_we_idle", bus.fb_we, 0);

        $display("[TB] clip saturation");
        base_we      = we_cycles;
        bus.in_x     = 11'h7FB;
        bus.in_y     = 11'd0;
        bus.in_color = 1'b1;
        bus.in_valid = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check_output("sat_below", bus.clip_count, 65534);
        repeat (6) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_output("sat_hold", bus.clip_count, 65535);
        repeat (2) @(posedge clk);
        #1;
        check_output("sat_final", bus.clip_count, 65535);
        check_output("sat_no_we", we_cycles - base_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
